// File: rtl/sram_master.sv
// Load/store initiator for an asynchronous cs/oe/we SRAM: big-endian sub-word loads and
// read-modify-write sub-word stores. Define SRAM_MASTER_ALIGN_TRAP_EN to trap misaligned requests.
module sram_master #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_din,
  input  logic [31:0]       sram_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              sram_cs_q, sram_cs_d;
  logic              sram_oe_q, sram_oe_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]       sram_din_q, sram_din_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              accept;
  logic              last;
  logic              misaligned;

  // Big-endian lanes: byte offset 0 is the most significant byte of the word.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{~lane, 3'b000} +: 8];
    h = word[{~lane[1], 4'b0000} +: 16];
    case (size)
      2'd0:    r = {{24{sgn & b[7]}}, b};
      2'd1:    r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rmw_merge(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    if (size == 2'd0) m[{~lane, 3'b000} +: 8] = wd[7:0];
    else              m[{~lane[1], 4'b0000} +: 16] = wd;
    return m;
  endfunction

`ifdef SRAM_MASTER_ALIGN_TRAP_EN
  logic rsp_err_q, rsp_err_d;
  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign accept = req_valid && (state_q == IDLE);
  assign last   = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      lane_q      <= '0;
      wdata_q     <= '0;
      sram_cs_q   <= 1'b0;
      sram_oe_q   <= 1'b0;
      sram_we_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef SRAM_MASTER_ALIGN_TRAP_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      sram_cs_q   <= sram_cs_d;
      sram_oe_q   <= sram_oe_d;
      sram_we_q   <= sram_we_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef SRAM_MASTER_ALIGN_TRAP_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Next state, phase counter and request latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    lane_d   = lane_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = req_addr[1:0];
          wdata_d  = req_wdata[15:0];
          if (misaligned)                  state_d = RESP;
          else if (req_we && req_size[1])  state_d = WR;
          else                             state_d = RD;
        end
      end
      RD: begin
        if (last) begin
          cnt_d   = '0;
          state_d = we_q ? WR : RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR: begin
        if (last) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered, so strobes change on the edge.
  always_comb begin
    sram_cs_d   = (state_d == RD) || (state_d == WR);
    sram_oe_d   = (state_d == RD);
    sram_we_d   = (state_d == WR);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    sram_addr_d = '0;
    if (sram_cs_d)
      sram_addr_d = (state_q == IDLE) ? {req_addr[ADDR_W-1:2], 2'b00} : sram_addr_q;
    sram_din_d = '0;
    if (state_d == WR) begin
      if (state_q == IDLE)    sram_din_d = req_wdata;
      else if (state_q == RD) sram_din_d = rmw_merge(sram_dout, size_q, lane_q, wdata_q);
      else                    sram_din_d = sram_din_q;
    end
    rsp_rdata_d = '0;
    if ((state_q == RD) && (state_d == RESP))
      rsp_rdata_d = load_extract(sram_dout, size_q, lane_q, signed_q);
`ifdef SRAM_MASTER_ALIGN_TRAP_EN
    rsp_err_d = (state_q == IDLE) && (state_d == RESP);
`endif
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sram_cs   = sram_cs_q;
  assign sram_oe   = sram_oe_q;
  assign sram_we   = sram_we_q;
  assign sram_addr = sram_addr_q;
  assign sram_din  = sram_din_q;
`ifdef SRAM_MASTER_ALIGN_TRAP_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_master.sv
// Bench for sram_master: one WAIT_CYCLES=1 and one WAIT_CYCLES=3 instance driven in lockstep,
// each with its own SRAM model, checked against a shift/mask reference of memory contents.
module tb_sram_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rdy [2];
  logic        rv  [2];
  logic [31:0] rd  [2];
  logic        err [2];
  logic        cs  [2];
  logic        oe  [2];
  logic        we  [2];
  logic [31:0] ad  [2];
  logic [31:0] din [2];
  logic [31:0] dout[2];

  logic [31:0] mem [2][1024];
  logic [31:0] ref_mem [1024];

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  sram_master #(.WAIT_CYCLES(1), .ADDR_W(32)) u_dut_w1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(err[0]), .sram_cs(cs[0]), .sram_oe(oe[0]),
    .sram_we(we[0]), .sram_addr(ad[0]), .sram_din(din[0]), .sram_dout(dout[0]));

  sram_master #(.WAIT_CYCLES(3), .ADDR_W(32)) u_dut_w3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(err[1]), .sram_cs(cs[1]), .sram_oe(oe[1]),
    .sram_we(we[1]), .sram_addr(ad[1]), .sram_din(din[1]), .sram_dout(dout[1]));

  assign dout[0] = (cs[0] && oe[0]) ? mem[0][ad[0][11:2]] : '0;
  assign dout[1] = (cs[1] && oe[1]) ? mem[1][ad[1][11:2]] : '0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (cs[d] && we[d]) mem[d][ad[d][11:2]] <= din[d];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] lo, input logic sg);
    int unsigned sh;
    logic [31:0] m, v;
    if (sz >= 2) return word;
    if (sz == 0) begin sh = 8 * (3 - lo); m = 32'h0000_00FF; end
    else         begin sh = 16 * (1 - lo[1]); m = 32'h0000_FFFF; end
    v = (word >> sh) & m;
    if (sg && ((v & ((m >> 1) + 1)) != 0)) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] lo, input logic [31:0] wd);
    int unsigned sh;
    logic [31:0] m;
    if (sz >= 2) return wd;
    if (sz == 0) begin sh = 8 * (3 - lo); m = 32'h0000_00FF << sh; end
    else         begin sh = 16 * (1 - lo[1]); m = 32'h0000_FFFF << sh; end
    return (word & ~m) | ((wd << sh) & m);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
  endfunction

  task automatic txn(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                     input string nm);
    int lat[2], ocnt[2], wcnt[2], bad[2];
    logic [31:0] grd[2];
    logic gerr[2];
    logic sub;
    logic [31:0] wa, nw;
    int wc, elat, eoe, ewe;
    sub = w && (sz < 2);
    wa  = {a[31:2], 2'b00};
    nw  = model_store(ref_mem[a[11:2]], sz, a[1:0], wd);
    for (int d = 0; d < 2; d++) begin
      lat[d] = 0; ocnt[d] = 0; wcnt[d] = 0; bad[d] = 0; grd[d] = '0; gerr[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s/d%0d/idle_rdy_rv", nm, d), {30'd0, rdy[d], rv[d]}, 32'd2);
    req_valid = 1'b1; req_we = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int cyc = 1; cyc <= 40 && (lat[0] == 0 || lat[1] == 0); cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (lat[d] == 0) begin
          if (oe[d]) ocnt[d]++;
          if (we[d]) begin
            wcnt[d]++;
            if (din[d] !== nw) bad[d]++;
          end
          if (cs[d] && ad[d] !== wa) bad[d]++;
          if (rdy[d]) bad[d]++;
          if (rv[d]) begin
            lat[d] = cyc; grd[d] = rd[d]; gerr[d] = err[d];
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      wc   = (d == 0) ? 1 : 3;
      elat = exp_err ? 1 : (sub ? 2 * wc + 1 : wc + 1);
      eoe  = exp_err ? 0 : ((!w || sub) ? wc : 0);
      ewe  = (exp_err || !w) ? 0 : wc;
      chk($sformatf("%s/w%0d/latency", nm, wc), 32'(lat[d]), 32'(elat));
      chk($sformatf("%s/w%0d/rdata", nm, wc), grd[d], exp_rd);
      chk($sformatf("%s/w%0d/err", nm, wc), {31'd0, gerr[d]}, {31'd0, exp_err});
      chk($sformatf("%s/w%0d/oe_cycles", nm, wc), 32'(ocnt[d]), 32'(eoe));
      chk($sformatf("%s/w%0d/we_cycles", nm, wc), 32'(wcnt[d]), 32'(ewe));
      chk($sformatf("%s/w%0d/addr_din_rdy", nm, wc), 32'(bad[d]), 32'd0);
    end
    if (w && !exp_err) ref_mem[a[11:2]] = nw;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] v, erd;
    logic        w, sg, er;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    int          nrv;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      v = (i == 32'h40) ? 32'h1122_3344 : $urandom;
      mem[0][i] <= v; mem[1][i] <= v; ref_mem[i] = v;
    end

    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,         32'h1122_3344};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_BEEF, 32'h0};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,         32'h1122_BEEF};
    vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_33F4, 32'h0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,         32'hFFFF_FFF4};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,         32'h0000_0011};
    vecs[6]  = '{1'b1, 2'd0, 1'b1, 32'h101, 32'hFFFF_FFA5, 32'h0};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,         32'h11A5_33F4};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h100, 32'h0,         32'h0000_11A5};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h101, 32'h0,         32'hFFFF_FFA5};
    vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFE_F00D, 32'h0};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h200, 32'h0,         32'hCAFE_F00D};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 32'h202, 32'h0,         32'h0000_F00D};
    vecs[13] = '{1'b0, 2'd1, 1'b1, 32'h202, 32'h0,         32'hFFFF_F00D};
    vecs[14] = '{1'b0, 2'd3, 1'b1, 32'h200, 32'h0,         32'hCAFE_F00D};

    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset/d%0d/ready", d), {31'd0, rdy[d]}, 32'd1);
      chk($sformatf("reset/d%0d/strobes_rv", d), {28'd0, cs[d], oe[d], we[d], rv[d]}, 32'd0);
      chk($sformatf("reset/d%0d/addr", d), ad[d], 32'd0);
      chk($sformatf("reset/d%0d/rdata", d), rd[d], 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++)
      txn(vecs[i].we, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0,
          $sformatf("vec%0d", i));

`ifdef SRAM_MASTER_ALIGN_TRAP_EN
    txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, "misaligned_word");
    txn(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 32'h0, 1'b1, "misaligned_half");
`else
    txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h11A5_33F4, 1'b0, "misaligned_word");
    txn(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 32'h0000_33F4, 1'b0, "misaligned_half");
`endif

    // Reset during the first write cycle of a word store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h300; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    chk("midrst/w3/pre_cs_we", {30'd0, cs[1], we[1]}, 32'd3);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst/d%0d/strobes", d), {29'd0, cs[d], oe[d], we[d]}, 32'd0);
      chk($sformatf("midrst/d%0d/ready", d), {31'd0, rdy[d]}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    nrv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (rv[d] || cs[d]) nrv++;
    end
    chk("midrst/no_rsp", 32'(nrv), 32'd0);
    for (int d = 0; d < 2; d++)
      chk($sformatf("midrst/d%0d/ready_after", d), {31'd0, rdy[d]}, 32'd1);

    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      a  = $urandom_range(0, 4095);
      wd = $urandom;
      er = 1'b0;
`ifdef SRAM_MASTER_ALIGN_TRAP_EN
      er = is_misaligned(sz, a);
`endif
      erd = (w || er) ? 32'h0 : model_load(ref_mem[a[11:2]], sz, a[1:0], sg);
      txn(w, sz, sg, a, wd, erd, er, $sformatf("rand%0d%s", i, is_misaligned(sz, a) ? "m" : ""));
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
